fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of write requesters (power of 2, 2..8).
REQ-002 SHALL have parameter D_WIDTH, default 8, meaning data word width, matching the downstream synchronous FIFO.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning maximum consecutive words accepted from one owner per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester word-available flag.
REQ-007 SHALL have port req_data  input  N_REQ*D_WIDTH  packed requester words; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester word-accepted strobe.
REQ-009 SHALL have port fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 SHALL have port fifo_w_en  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_data_in  output  D_WIDTH  FIFO write data.
REQ-012 SHALL have port grant_id  output  log2(N_REQ)  index of the current owner.
REQ-013 SHALL have port busy  output  1  high while in state OWN.
REQ-014 SHALL have port wr_count  output  16  total words written to the FIFO.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and OWN.
REQ-016 In IDLE with any req_valid high, SHALL register owner = first index with req_valid high, searched upward from rr_ptr with wrap; next state OWN; beat_cnt = 0.
REQ-017 In IDLE with no req_valid high, SHALL remain in IDLE with owner and rr_ptr unchanged.
REQ-018 In OWN, req_ready[owner] SHALL be combinational: req_valid[owner] & !fifo_full; all other req_ready bits 0.
REQ-019 req_ready SHALL be all zero in IDLE.
REQ-020 fifo_w_en SHALL equal req_ready[owner] (combinational); fifo_data_in SHALL be req_data of owner in every state.
REQ-021 A transfer is fifo_w_en high at a rising clk edge; each transfer SHALL increment beat_cnt and wr_count.
REQ-022 wr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 In OWN, a transfer that makes beat_cnt reach MAX_BURST SHALL cause transition to IDLE, with rr_ptr = (owner+1) mod N_REQ.
REQ-024 In OWN, req_valid[owner] low SHALL cause transition to IDLE, with rr_ptr = (owner+1) mod N_REQ; no transfer occurs that cycle.
REQ-025 In OWN with fifo_full high and req_valid[owner] high, SHALL hold OWN with no transfer and no beat_cnt change; stalls do not release the grant.
REQ-026 Arbitration latency SHALL be one cycle (IDLE to OWN); first write possible in the first OWN cycle.
REQ-027 Minimum gap between owners SHALL be one IDLE cycle; the FIFO sees at most MAX_BURST words per MAX_BURST+1 cycles from one requester under contention.
REQ-028 grant_id SHALL equal the registered owner; busy SHALL be 1 exactly in OWN.
REQ-029 Requesters SHALL hold req_data stable while req_valid is high and req_ready is low; the block never drops or duplicates a word.

Reset
REQ-030 With rst high, SHALL force state IDLE, owner 0, rr_ptr 0, beat_cnt 0, wr_count 0, immediately and without a clock.
REQ-031 During reset, req_ready, fifo_w_en, grant_id and busy SHALL read 0; fifo_data_in SHALL equal req_data[D_WIDTH-1:0].
REQ-032 Reset asserted mid-burst SHALL abort the grant; no fifo_w_en in the cycle after deassertion, and arbitration restarts from requester 0.

Verification
REQ-033 Single requester: req_valid=4'b0100 continuous, fifo_full=0 -> grant_id=2; 4 writes, 1 IDLE cycle, repeat; wr_count=8 after 10 cycles of OWN/IDLE.
REQ-034 All-request rotation: req_valid=4'b1111 continuous -> grant order 0,1,2,3,0; 4 words each; data order in FIFO matches per-requester order (scoreboard queue per requester).
REQ-035 Backpressure: owner 1 mid-burst at beat_cnt=2, fifo_full=1 for 3 cycles -> req_ready=0, fifo_w_en=0, grant held; after release 2 more words then IDLE.
REQ-036 Early release: owner 3 drops req_valid after 1 word -> IDLE next cycle, rr_ptr=0; pending requester 0 granted next.
REQ-037 Reset mid-burst: rst pulse while owner=2, beat_cnt=3 -> all outputs 0 immediately; after release, with req_valid=4'b0110, requester 1 granted first.
REQ-038 Counter wrap: preload via 65535 transfers, one more -> wr_count=0x0000.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin write arbiter feeding one synchronous FIFO. The
//            winner keeps the grant for up to MAX_BURST words, then the
//            grant returns to IDLE for one cycle before the next owner is
//            picked. FIFO backpressure stalls the owner without releasing
//            the grant.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_w_en,
    output logic [D_WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic [15:0]                  wr_count
);

    localparam int c_ID_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_ID_W-1:0]   r_owner;
    logic [c_ID_W-1:0]   w_owner_next;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   w_rr_next;
    logic [3:0]          r_beat_cnt;
    logic [3:0]          w_beat_next;
    logic [15:0]         r_wr_count;
    logic                w_found;
    logic [c_ID_W-1:0]   w_pick;
    logic                w_xfer;

    // Round-robin search: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [c_ID_W-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        v_idx   = r_rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = r_rr_ptr + c_ID_W'(k);
            if (req_valid[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Handshake: only the owner may be accepted, and only when the FIFO has room.
    always_comb begin
        w_xfer    = (r_state == S_OWN) && req_valid[r_owner] && !fifo_full;
        req_ready = '0;
        if (w_xfer) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    // Next-state logic: grant on demand, release on burst limit or owner drop.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr_ptr;
        w_beat_next  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_OWN;
                    w_owner_next = w_pick;
                    w_beat_next  = 4'd0;
                end
            end
            S_OWN: begin
                if (!req_valid[r_owner]) begin
                    w_state_next = S_IDLE;
                    w_rr_next    = r_owner + c_ID_W'(1);
                end else if (w_xfer) begin
                    w_beat_next = r_beat_cnt + 4'd1;
                    if ((r_beat_cnt + 4'd1) == 4'(MAX_BURST)) begin
                        w_state_next = S_IDLE;
                        w_rr_next    = r_owner + c_ID_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, owner, pointer and burst counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_rr_ptr   <= w_rr_next;
            r_beat_cnt <= w_beat_next;
        end
    end

    // Running count of words written to the FIFO; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= 16'd0;
        end else if (w_xfer) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign fifo_w_en    = w_xfer;
    assign fifo_data_in = req_data[r_owner*D_WIDTH +: D_WIDTH];
    assign grant_id     = r_owner;
    assign busy         = (r_state == S_OWN);
    assign wr_count     = r_wr_count;

endmodule
`default_nettype wire
